// File: rtl/cpu_fetch_if.sv
// Instruction memory port of the fetch stage: single-outstanding request/ack.
interface cpu_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/cpu_fetch.sv
// mox125 instruction fetch/align: fetches halfwords into a small FIFO and
// issues one short (1 halfword) or long (3 halfword) instruction per cycle.
module cpu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int          DEPTH    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cpu_fetch_if.master        imem,
    input  logic               branch_flag_i,
    input  logic        [31:0] branch_target_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic        [15:0] opcode_o,
    output logic        [31:0] operand_o,
    output logic        [31:0] PC_o,
    output logic               valid_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Opcodes whose high byte marks a 3-halfword instruction.
    function automatic logic is_long(input logic [15:0] op);
        case (op[15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long = 1'b1;
            default: is_long = 1'b0;
        endcase
    endfunction

    logic [15:0]   fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   tgt_q, tgt_d;
    logic          discard_q, discard_d;
    logic [15:0]   opcode_q, opcode_d;
    logic [31:0]   operand_q, operand_d;
    logic [31:0]   pc_q, pc_d;
    logic          valid_q, valid_d;

    logic          req, accept, push;
    logic [1:0]    pop_n;
    logic [15:0]   hw0, hw1, hw2;
    logic [31:0]   target_even;

    // The request stays up until acked: count cannot grow without an ack,
    // and a pending discard only clears on an ack.
    assign req              = rst_i & (discard_q | (count_q < CW'(DEPTH)));
    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = addr_q;
    assign accept           = req & imem.imem_ack_i;
    assign target_even      = branch_target_i & ~32'h1;

    assign hw0 = fifo_q[rd_ptr_q];
    assign hw1 = fifo_q[rd_ptr_q + PW'(1)];
    assign hw2 = fifo_q[rd_ptr_q + PW'(2)];

    assign opcode_o  = opcode_q;
    assign operand_o = operand_q;
    assign PC_o      = pc_q;
    assign valid_o   = valid_q;

    // Next-state: branch redirect, fetch advance/discard, and instruction issue.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_pc_d = head_pc_q;
        addr_d    = addr_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        push      = 1'b0;
        pop_n     = 2'd0;

        if (branch_flag_i) begin
            valid_d   = 1'b0;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            head_pc_d = target_even;
            if (req && !imem.imem_ack_i) begin
                // Old request still in flight: keep it up, drop its data later.
                discard_d = 1'b1;
                tgt_d     = target_even;
            end else begin
                // Any ack this cycle belongs to the old stream and is dropped.
                discard_d = 1'b0;
                addr_d    = target_even;
            end
        end else begin
            if (accept) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    addr_d    = tgt_q;
                end else begin
                    push   = 1'b1;
                    addr_d = addr_q + 32'd2;
                end
            end

            if (flush_i) begin
                valid_d = 1'b0;
            end else if (!stall_i) begin
                if (!is_long(hw0) && count_q >= CW'(1)) begin
                    opcode_d  = hw0;
                    operand_d = '0;
                    pc_d      = head_pc_q;
                    valid_d   = 1'b1;
                    pop_n     = 2'd1;
                end else if (is_long(hw0) && count_q >= CW'(3)) begin
                    opcode_d  = hw0;
                    operand_d = {hw1, hw2};
                    pc_d      = head_pc_q;
                    valid_d   = 1'b1;
                    pop_n     = 2'd3;
                end else begin
                    valid_d = 1'b0;
                end
            end

            count_d   = count_q + CW'(push) - CW'(pop_n);
            wr_ptr_d  = wr_ptr_q + PW'(push);
            rd_ptr_d  = rd_ptr_q + PW'(pop_n);
            head_pc_d = head_pc_q + {29'd0, pop_n, 1'b0};
        end
    end

    // Control and presented-instruction state, asynchronously reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
            addr_q    <= RESET_PC;
            tgt_q     <= RESET_PC;
            discard_q <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            addr_q    <= addr_d;
            tgt_q     <= tgt_d;
            discard_q <= discard_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
        end
    end

    // Halfword storage; only written on an accepted, non-discarded ack.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= imem.imem_data_i;
        end
    end
endmodule
